bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock. It supersedes the fixed 32-bit combinational converter on display paths where a wide unrolled adder chain breaks timing. It adds:
- configurable input width and digit count;
- optional signed (two's complement) input;
- overflow detection;
- significant-digit count for leading-zero blanking;
- valid/ready handshakes on both sides.

---
 rtl/bin2bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with optional signed input, overflow flag and significant-digit count.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 10,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*DIGITS-1:0]           out_bcd,
    output logic                          out_neg,
    output logic [$clog2(DIGITS+1)-1:0]   out_ndig,
    output logic                          out_ovf
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj_c;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               neg;
    logic [NDIG_W-1:0]  ndig_c;
    logic               in_neg_c;

    assign in_neg_c = SIGNED && in_data[BIN_W-1];

    // Add-3 correction on every digit above 4 before the shift.
    always_comb begin
        acc_adj_c = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] > 4'd4) begin
                acc_adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Significant digits: highest nonzero digit + 1, minimum 1, full width on overflow.
    always_comb begin
        ndig_c = NDIG_W'(1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] != 4'd0) begin
                ndig_c = NDIG_W'(i + 1);
            end
        end
        if (ovf) begin
            ndig_c = NDIG_W'(DIGITS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mag       <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            neg       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_neg   <= 1'b0;
            out_ndig  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Negation in BIN_W bits keeps -2^(BIN_W-1) exact as unsigned.
                        mag      <= in_neg_c ? (~in_data + BIN_W'(1)) : in_data;
                        neg      <= in_neg_c;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        cnt      <= CNT_W'(BIN_W);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {acc_adj_c[BCD_W-2:0], mag[BIN_W-1]};
                    mag <= {mag[BIN_W-2:0], 1'b0};
                    ovf <= ovf | acc_adj_c[BCD_W-1];
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    out_bcd   <= acc;
                    out_neg   <= neg;
                    out_ovf   <= ovf;
                    out_ndig  <= ndig_c;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 32/10 unsigned, 8/3 signed and 16/4 overflow
// instances sharing clock and reset.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 32-bit unsigned, 10 digits
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [31:0] a_in_data = '0;
    logic [39:0] a_out_bcd;
    logic        a_out_neg, a_out_ovf;
    logic [3:0]  a_out_ndig;

    bin2bcd_seq #(.BIN_W(32), .DIGITS(10), .SIGNED(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_neg(a_out_neg), .out_ndig(a_out_ndig), .out_ovf(a_out_ovf)
    );

    // 8-bit signed, 3 digits
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic [11:0] b_out_bcd;
    logic        b_out_neg, b_out_ovf;
    logic [1:0]  b_out_ndig;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_neg(b_out_neg), .out_ndig(b_out_ndig), .out_ovf(b_out_ovf)
    );

    // 16-bit unsigned, 4 digits (overflow possible)
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [15:0] c_in_data = '0;
    logic [15:0] c_out_bcd;
    logic        c_out_neg, c_out_ovf;
    logic [2:0]  c_out_ndig;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_bcd(c_out_bcd), .out_neg(c_out_neg), .out_ndig(c_out_ndig), .out_ovf(c_out_ovf)
    );

    // One 32-bit conversion; 'hold' cycles of backpressure with a stray in_valid pulse.
    task automatic run_a(input string tag, input logic [31:0] d, input logic [39:0] bcd,
                         input int nd, input int hold);
        int cyc;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(a_in_ready), 64'(1));
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        cyc = 0;
        while (!a_out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(33));
        check({tag, " bcd"}, 64'(a_out_bcd), 64'(bcd));
        check({tag, " ndig"}, 64'(a_out_ndig), 64'(nd));
        check({tag, " ovf"}, 64'(a_out_ovf), 64'(0));
        check({tag, " neg"}, 64'(a_out_neg), 64'(0));
        for (int h = 0; h < hold; h++) begin
            a_in_valid = (h == 1);
            a_in_data  = 32'h0000_0007;
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 64'(a_out_valid), 64'(1));
            check({tag, " hold ready"}, 64'(a_in_ready), 64'(0));
            check({tag, " hold bcd"}, 64'(a_out_bcd), 64'(bcd));
            check({tag, " hold ndig"}, 64'(a_out_ndig), 64'(nd));
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        check({tag, " release valid"}, 64'(a_out_valid), 64'(0));
        check({tag, " release ready"}, 64'(a_in_ready), 64'(1));
        check({tag, " retained bcd"}, 64'(a_out_bcd), 64'(bcd));
        if (hold > 0) begin
            @(posedge clk);
            #1 check({tag, " stray ignored"}, 64'(a_in_ready), 64'(1));
        end
    endtask

    task automatic run_b(input string tag, input logic [7:0] d, input logic [11:0] bcd,
                         input int nd, input logic ng);
        int cyc;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        cyc = 0;
        while (!b_out_valid && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(9));
        check({tag, " bcd"}, 64'(b_out_bcd), 64'(bcd));
        check({tag, " ndig"}, 64'(b_out_ndig), 64'(nd));
        check({tag, " neg"}, 64'(b_out_neg), 64'(ng));
        check({tag, " ovf"}, 64'(b_out_ovf), 64'(0));
        b_out_ready = 1'b1;
        @(posedge clk);
        #1 b_out_ready = 1'b0;
        check({tag, " release"}, 64'(b_out_valid), 64'(0));
    endtask

    // out_ready is raised before out_valid: HOLD must last exactly one cycle.
    task automatic run_c(input string tag, input logic [15:0] d, input logic [15:0] bcd,
                         input int nd, input logic ov);
        int cyc;
        @(negedge clk);
        c_in_valid  = 1'b1;
        c_in_data   = d;
        c_out_ready = 1'b1;
        @(posedge clk);
        #1 c_in_valid = 1'b0;
        cyc = 0;
        while (!c_out_valid && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(17));
        check({tag, " bcd"}, 64'(c_out_bcd), 64'(bcd));
        check({tag, " ndig"}, 64'(c_out_ndig), 64'(nd));
        check({tag, " ovf"}, 64'(c_out_ovf), 64'(ov));
        @(posedge clk);
        #1;
        check({tag, " one-cycle hold"}, 64'(c_out_valid), 64'(0));
        check({tag, " ready back"}, 64'(c_in_ready), 64'(1));
        c_out_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(a_in_ready), 64'(1));
        check("reset out_valid", 64'(a_out_valid), 64'(0));
        check("reset bcd", 64'(a_out_bcd), 64'(0));
        check("reset ndig", 64'(a_out_ndig), 64'(0));
        check("reset ovf/neg", 64'({a_out_ovf, a_out_neg}), 64'(0));
        rst = 1'b0;

        run_a("a max", 32'hFFFF_FFFF, 40'h42_9496_7295, 10, 0);
        run_a("a zero", 32'h0, 40'h0, 1, 0);
        run_a("a 1029 bp", 32'h0000_0405, 40'h00_0000_1029, 4, 5);

        // Abort after 10 shift edges; outputs must clear and no result may appear.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 32'h1234_5678;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort in_ready", 64'(a_in_ready), 64'(1));
        check("abort out_valid", 64'(a_out_valid), 64'(0));
        check("abort bcd", 64'(a_out_bcd), 64'(0));
        check("abort ndig", 64'(a_out_ndig), 64'(0));
        // in_valid together with rst must not be accepted
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        rst = 1'b0;
        check("rst wins", 64'(a_in_ready), 64'(1));
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1 if (a_out_valid) seen = 1'b1;
        end
        check("no aborted result", 64'(seen), 64'(0));
        run_a("a after abort", 32'hFFFF_FFFF, 40'h42_9496_7295, 10, 0);

        run_b("s 0x80", 8'h80, 12'h128, 3, 1'b1);
        run_b("s 0xFF", 8'hFF, 12'h001, 1, 1'b1);
        run_b("s 0x7F", 8'h7F, 12'h127, 3, 1'b0);
        run_b("s 0x00", 8'h00, 12'h000, 1, 1'b0);

        run_c("o 65535", 16'hFFFF, 16'h5535, 4, 1'b1);
        run_c("o 9999", 16'h270F, 16'h9999, 4, 1'b0);
        run_c("o 10000", 16'h2710, 16'h0000, 4, 1'b1);
        run_c("o 7", 16'h0007, 16'h0007, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
